// File: rtl/external_input_pkg.sv
// Shared definitions for the external input block: data width, default
// parameters and the debounce state encoding.
package external_input_pkg;

    // Width of the DIP-switch word delivered to the CPU.
    localparam int unsigned DATA_W = 16;

    // Width of the debounce counter.
    localparam int unsigned DEB_CNT_W = 16;

    // Default number of stable cycles that qualify a button edge.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

    // Default number of buffered words (power of two).
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

endpackage : external_input_pkg

// File: rtl/input_fifo.sv
// Small FIFO holding captured switch words until the CPU reads them.
// Ports:
//   clock, reset   : clock and asynchronous active-low reset
//   wr_en, wr_data : capture request and word to store
//   rd_en          : read request (ignored while empty)
//   rd_data        : current head entry (combinational from storage)
//   count          : registered number of stored entries
// A write while full is accepted only when a read happens at the same edge.
module input_fifo
    import external_input_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_rd;
    logic              do_wr;

    // Read only when something is stored; write when there is room, or when
    // a simultaneous read frees the slot.
    assign do_rd = rd_en && (count_q != '0);
    assign do_wr = wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);

    // Storage needs no reset; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

endmodule : input_fifo

// File: rtl/external_input.sv
// External input port: synchronizes a DIP-switch word and a bouncing enter
// button, debounces the button, buffers one switch word per press in a FIFO
// and hands words to the CPU on IN-instruction reads.
// Ports:
//   clock, reset               : clock and asynchronous active-low reset
//   switch                     : raw switch word (asynchronous)
//   enterButton                : raw push button (asynchronous, bouncing)
//   inputEnable, changeEnable  : a read happens when both are high
//   DR                         : registered word delivered to the CPU
//   dataReady, full            : FIFO non-empty / FIFO full (from count)
//   overflow                   : sticky, a captured word was dropped
module external_input
    import external_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] switch,
    input  logic              enterButton,
    input  logic              inputEnable,
    input  logic              changeEnable,
    output logic [DATA_W-1:0] DR,
    output logic              dataReady,
    output logic              full,
    output logic              overflow
);

    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0]     sw_meta;
    logic [DATA_W-1:0]     sw_sync;
    logic                  btn_meta;
    logic                  btn_sync;

    deb_state_e            state_q;
    deb_state_e            state_d;
    logic [DEB_CNT_W-1:0]  cnt_q;
    logic [DEB_CNT_W-1:0]  cnt_d;
    logic                  capture_c;

    logic                  rd_req;
    logic [DATA_W-1:0]     fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;

    // Two-flop synchronizers for the button and every switch bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sw_meta  <= switch;
            sw_sync  <= sw_meta;
            btn_meta <= enterButton;
            btn_sync <= btn_meta;
        end
    end

    // Debounce state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce next state: a press must be stable for DEBOUNCE_CYCLES to
    // issue one capture; release must be equally stable before re-arming.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = HELD;
                    capture_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + DEB_CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = HELD;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DEB_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rd_req = inputEnable && changeEnable;

    input_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (capture_c),
        .wr_data (sw_sync),
        .rd_en   (rd_req),
        .rd_data (fifo_head),
        .count   (fifo_count)
    );

    assign dataReady = (fifo_count != '0);
    assign full      = (fifo_count == FIFO_CNT_W'(FIFO_DEPTH));

    // DR takes the head word at the same edge the FIFO pops it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            DR <= '0;
        end else if (rd_req && dataReady) begin
            DR <= fifo_head;
        end
    end

    // A capture is dropped only when full with no read freeing a slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (capture_c && full && !rd_req) begin
            overflow <= 1'b1;
        end
    end

endmodule : external_input

// File: tb/tb_external_input.sv
// Directed testbench for external_input with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_external_input;

    localparam int unsigned DC = 4;
    localparam int unsigned FD = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] switch;
    logic        enterButton;
    logic        inputEnable;
    logic        changeEnable;
    logic [15:0] DR;
    logic        dataReady;
    logic        full;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    external_input #(
        .DEBOUNCE_CYCLES (DC),
        .FIFO_DEPTH      (FD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .switch       (switch),
        .enterButton  (enterButton),
        .inputEnable  (inputEnable),
        .changeEnable (changeEnable),
        .DR           (DR),
        .dataReady    (dataReady),
        .full         (full),
        .overflow     (overflow)
    );

    // Advance n rising edges, then settle 1ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Clean press: hold the button, then release long enough to re-arm.
    task automatic press(input logic [15:0] sw, input int hold);
        switch      = sw;
        enterButton = 1'b1;
        tick(hold);
        enterButton = 1'b0;
        tick(10);
    endtask

    task automatic read_word();
        inputEnable  = 1'b1;
        changeEnable = 1'b1;
        tick(1);
        inputEnable  = 1'b0;
        changeEnable = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        reset        = 1'b0;
        switch       = 16'h0000;
        enterButton  = 1'b0;
        inputEnable  = 1'b0;
        changeEnable = 1'b0;
        tick(3);
        chk("rst_dr",        DR,               16'h0000);
        chk("rst_ready",     16'(dataReady),   16'h0000);
        chk("rst_full",      16'(full),        16'h0000);
        chk("rst_overflow",  16'(overflow),    16'h0000);
        reset = 1'b1;
        tick(1);

        // Glitchy press: single-cycle pulses must not capture.
        switch = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            enterButton = 1'b1;
            tick(1);
            enterButton = 1'b0;
            tick(1);
        end
        tick(3);
        chk("glitch_no_capture", 16'(dataReady), 16'h0000);
        enterButton = 1'b1;
        tick(10);
        enterButton = 1'b0;
        tick(10);
        chk("glitch_ready",  16'(dataReady), 16'h0001);
        chk("glitch_full",   16'(full),      16'h0000);
        read_word();
        chk("glitch_dr",       DR,               16'h1234);
        chk("glitch_drained",  16'(dataReady),   16'h0000);

        // Fill to full, then overflow on the fifth press.
        for (int i = 1; i <= 4; i++) begin
            press(16'(i), 10);
            chk("fill_full", 16'(full), (i == 4) ? 16'h0001 : 16'h0000);
            chk("fill_ovf",  16'(overflow), 16'h0000);
        end
        press(16'h0005, 10);
        chk("ovf_set",  16'(overflow), 16'h0001);
        chk("ovf_full", 16'(full),     16'h0001);
        inputEnable = 1'b1;
        tick(1);
        inputEnable = 1'b0;
        chk("half_strobe_dr",   DR,           16'h1234);
        chk("half_strobe_full", 16'(full),    16'h0001);
        for (int i = 1; i <= 4; i++) begin
            read_word();
            chk("drain_dr", DR, 16'(i));
        end
        chk("drain_ready",  16'(dataReady), 16'h0000);
        chk("drain_full",   16'(full),      16'h0000);
        chk("ovf_sticky",   16'(overflow),  16'h0001);

        // Full FIFO: capture coincides with a read.
        apply_reset();
        chk("rst2_ovf", 16'(overflow), 16'h0000);
        chk("rst2_dr",  DR,            16'h0000);
        for (int i = 1; i <= 4; i++) press(16'h00A0 + 16'(i), 10);
        chk("full_before", 16'(full), 16'h0001);
        switch      = 16'h00A5;
        enterButton = 1'b1;
        tick(6);
        inputEnable  = 1'b1;
        changeEnable = 1'b1;
        tick(1);
        inputEnable  = 1'b0;
        changeEnable = 1'b0;
        chk("cowr_dr",   DR,            16'h00A1);
        chk("cowr_full", 16'(full),     16'h0001);
        chk("cowr_ovf",  16'(overflow), 16'h0000);
        tick(3);
        enterButton = 1'b0;
        tick(10);
        chk("cowr_ovf_later", 16'(overflow), 16'h0000);
        for (int i = 2; i <= 5; i++) begin
            read_word();
            chk("cowr_drain", DR, 16'h00A0 + 16'(i));
        end
        chk("cowr_empty", 16'(dataReady), 16'h0000);

        // Read while empty keeps DR and pointers.
        press(16'hBEEF, 10);
        read_word();
        chk("beef_dr", DR, 16'hBEEF);
        read_word();
        chk("empty_rd_dr",    DR,             16'hBEEF);
        chk("empty_rd_ready", 16'(dataReady), 16'h0000);
        press(16'h1111, 10);
        read_word();
        chk("after_empty_dr", DR, 16'h1111);

        // Empty FIFO: capture and read together perform only the write.
        switch      = 16'h2222;
        enterButton = 1'b1;
        tick(6);
        inputEnable  = 1'b1;
        changeEnable = 1'b1;
        tick(1);
        inputEnable  = 1'b0;
        changeEnable = 1'b0;
        chk("empty_cowr_dr",    DR,             16'h1111);
        chk("empty_cowr_ready", 16'(dataReady), 16'h0001);
        tick(3);
        enterButton = 1'b0;
        tick(10);
        read_word();
        chk("empty_cowr_word", DR,             16'h2222);
        chk("empty_cowr_done", 16'(dataReady), 16'h0000);

        // Long hold: no auto-repeat; re-press captures again.
        press(16'h3333, 100);
        read_word();
        chk("hold_dr",    DR,             16'h3333);
        chk("hold_once",  16'(dataReady), 16'h0000);
        press(16'h4444, 10);
        read_word();
        chk("repress_dr",   DR,             16'h4444);
        chk("repress_once", 16'(dataReady), 16'h0000);

        // Reset during PRESS_WAIT with two entries stored.
        apply_reset();
        press(16'h5555, 10);
        press(16'h6666, 10);
        press(16'h7777, 10);
        read_word();
        chk("pre_rst_dr",    DR,             16'h5555);
        chk("pre_rst_ready", 16'(dataReady), 16'h0001);
        switch      = 16'h8888;
        enterButton = 1'b1;
        tick(4);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_dr",    DR,             16'h0000);
        chk("async_rst_ready", 16'(dataReady), 16'h0000);
        chk("async_rst_full",  16'(full),      16'h0000);
        chk("async_rst_ovf",   16'(overflow),  16'h0000);
        enterButton = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(20);
        chk("no_capture_ready", 16'(dataReady), 16'h0000);
        chk("no_capture_dr",    DR,             16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_external_input
